wfg_drive_spi_mc: RTL and testbench

Parametrised SPI master driver for the waveform generator. It serialises AXI-stream words onto an SPI bus with NUM_CS chip selects. Frame length, all four CPOL/CPHA modes and bit order are runtime-configurable. An optional burst mode holds chip select across consecutive frames until tlast, and a programmable inter-frame gap separates frames. The block sits downstream of the pattern sync core and is fed by the stream interconnect, like the other wfg_drive_* blocks.

---
 rtl/wfg_drive_spi_mc.sv | 169 ++++++++++++++++
 tb/tb_wfg_drive_spi_mc.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wfg_drive_spi_mc.sv
// SPI master driver for the waveform generator: serialises AXI-stream words onto
// an SPI bus with runtime-selectable chip select, SPI mode, bit order and burst framing.
module wfg_drive_spi_mc #(
    parameter int  AXIS_DATA_WIDTH = 32,
    parameter int  NUM_CS          = 4,
    parameter int  DIV_WIDTH       = 8,
    localparam int FLW             = $clog2(AXIS_DATA_WIDTH),
    localparam int CSW             = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wfg_pat_sync_i,
    output logic                       wfg_axis_tready_o,
    input  logic                       wfg_axis_tvalid_i,
    input  logic                       wfg_axis_tlast_i,
    input  logic [AXIS_DATA_WIDTH-1:0] wfg_axis_tdata_i,
    input  logic                       ctrl_en_q_i,
    input  logic [DIV_WIDTH-1:0]       clkcfg_div_q_i,
    input  logic [FLW-1:0]             cfg_flen_q_i,
    input  logic                       cfg_cpol_q_i,
    input  logic                       cfg_cpha_q_i,
    input  logic                       cfg_lsbfirst_q_i,
    input  logic [CSW-1:0]             cfg_cs_sel_q_i,
    input  logic                       cfg_sspol_q_i,
    input  logic                       cfg_burst_q_i,
    input  logic [7:0]                 cfg_gap_q_i,
    output logic                       wfg_drive_spi_sclk_o,
    output logic [NUM_CS-1:0]          wfg_drive_spi_cs_no,
    output logic                       wfg_drive_spi_sdo_o,
    output logic                       busy_o,
    output logic [2:0]                 dbg_state_o
);

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, HOLD, GAP} state_t;

    state_t                     state;
    logic [DIV_WIDTH-1:0]       div_cnt, div_l;
    logic [7:0]                 gap_cnt, gap_l;
    logic [FLW-1:0]             bit_cnt, flen_l, bit_sel;
    logic                       phase;
    logic [AXIS_DATA_WIDTH-1:0] data_q;
    logic                       last_q;
    logic                       cpol_l, cpha_l, lsb_l, sspol_l, burst_l;
    logic [CSW-1:0]             cs_sel_l;
    logic                       sclk_d, sdo_d;
    logic [NUM_CS-1:0]          cs_d;
    logic                       hs, half_done;

    // A beat transfers in any cycle where tvalid and tready are both high; tready
    // never depends on tvalid, and tvalid/tdata/tlast are sampled only on that cycle.
    assign wfg_axis_tready_o = ((state == IDLE) & wfg_pat_sync_i & ctrl_en_q_i) |
                               ((state == HOLD) & ctrl_en_q_i);
    assign hs          = wfg_axis_tvalid_i & wfg_axis_tready_o;
    assign half_done   = (div_cnt == '0);
    assign busy_o      = (state != IDLE);
    assign dbg_state_o = state;

    // Next pin levels; the pin flops make every SPI pin lag the state by one cycle.
    always_comb begin
        bit_sel = lsb_l ? bit_cnt : flen_l - bit_cnt;
        sclk_d  = cpol_l;
        sdo_d   = 1'b0;
        cs_d    = {NUM_CS{~sspol_l}};
        case (state)
            IDLE: begin
                sclk_d = cfg_cpol_q_i;
                cs_d   = {NUM_CS{~cfg_sspol_q_i}};
            end
            SHIFT: begin
                sclk_d = (phase ^ cpha_l) ^ cpol_l;
                sdo_d  = data_q[bit_sel];
            end
            default: ;
        endcase
        if (state inside {LEAD, SHIFT, TRAIL, HOLD}) begin
            for (int i = 0; i < NUM_CS; i++) begin
                if (int'(cs_sel_l) == i) cs_d[i] = sspol_l;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= IDLE;
            div_cnt              <= '0;
            div_l                <= '0;
            gap_cnt              <= '0;
            gap_l                <= '0;
            bit_cnt              <= '0;
            flen_l               <= '0;
            phase                <= 1'b0;
            data_q               <= '0;
            last_q               <= 1'b0;
            cpol_l               <= 1'b0;
            cpha_l               <= 1'b0;
            lsb_l                <= 1'b0;
            sspol_l              <= 1'b0;
            burst_l              <= 1'b0;
            cs_sel_l             <= '0;
            wfg_drive_spi_sclk_o <= 1'b0;
            wfg_drive_spi_sdo_o  <= 1'b0;
            wfg_drive_spi_cs_no  <= '1;
        end else begin
            wfg_drive_spi_sclk_o <= sclk_d;
            wfg_drive_spi_sdo_o  <= sdo_d;
            wfg_drive_spi_cs_no  <= cs_d;

            // IDLE/HOLD preload the divider so the next timed state starts a full half-period.
            if (state == IDLE)      div_cnt <= clkcfg_div_q_i;
            else if (state == HOLD) div_cnt <= div_l;
            else if (half_done)     div_cnt <= div_l;
            else                    div_cnt <= div_cnt - DIV_WIDTH'(1);

            case (state)
                IDLE: if (hs) begin
                    data_q   <= wfg_axis_tdata_i;
                    last_q   <= wfg_axis_tlast_i;
                    div_l    <= clkcfg_div_q_i;
                    gap_l    <= cfg_gap_q_i;
                    flen_l   <= cfg_flen_q_i;
                    cpol_l   <= cfg_cpol_q_i;
                    cpha_l   <= cfg_cpha_q_i;
                    lsb_l    <= cfg_lsbfirst_q_i;
                    sspol_l  <= cfg_sspol_q_i;
                    burst_l  <= cfg_burst_q_i;
                    cs_sel_l <= cfg_cs_sel_q_i;
                    state    <= LEAD;
                end
                LEAD: if (half_done) begin
                    phase   <= 1'b0;
                    bit_cnt <= '0;
                    state   <= SHIFT;
                end
                SHIFT: if (half_done) begin
                    if (!phase) begin
                        phase <= 1'b1;
                    end else if (bit_cnt == flen_l) begin
                        state <= TRAIL;
                    end else begin
                        phase   <= 1'b0;
                        bit_cnt <= bit_cnt + FLW'(1);
                    end
                end
                TRAIL: if (half_done) begin
                    gap_cnt <= gap_l;
                    state   <= (burst_l && !last_q && ctrl_en_q_i) ? HOLD : GAP;
                end
                HOLD: begin
                    if (hs) begin
                        data_q  <= wfg_axis_tdata_i;
                        last_q  <= wfg_axis_tlast_i;
                        phase   <= 1'b0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end else if (!ctrl_en_q_i) begin
                        gap_cnt <= gap_l;
                        state   <= GAP;
                    end
                end
                GAP: if (half_done) begin
                    if (gap_cnt == '0) state <= IDLE;
                    else               gap_cnt <= gap_cnt - 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wfg_drive_spi_mc.sv
// Directed bench for wfg_drive_spi_mc: frames are captured from the SPI pins and
// compared with hand-computed words, durations and pin levels.
module tb_wfg_drive_spi_mc;

    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sync, tready, tvalid, tlast;
    logic [31:0] tdata;
    logic        en;
    logic [7:0]  div;
    logic [4:0]  flen;
    logic        cpol, cpha, lsb, sspol, burst;
    logic [1:0]  cs_sel;
    logic [7:0]  gap;
    logic        sclk, sdo, busy;
    logic [3:0]  cs_no;
    logic [2:0]  dbg_state;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    int          cap_cs_cycles, cap_edges, cap_runs, cap_other, cap_busy_falls;
    int          cap_gap, cap_bad_launch, cap_timeout;
    logic [31:0] cap_rx;

    wfg_drive_spi_mc dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .wfg_pat_sync_i       (sync),
        .wfg_axis_tready_o    (tready),
        .wfg_axis_tvalid_i    (tvalid),
        .wfg_axis_tlast_i     (tlast),
        .wfg_axis_tdata_i     (tdata),
        .ctrl_en_q_i          (en),
        .clkcfg_div_q_i       (div),
        .cfg_flen_q_i         (flen),
        .cfg_cpol_q_i         (cpol),
        .cfg_cpha_q_i         (cpha),
        .cfg_lsbfirst_q_i     (lsb),
        .cfg_cs_sel_q_i       (cs_sel),
        .cfg_sspol_q_i        (sspol),
        .cfg_burst_q_i        (burst),
        .cfg_gap_q_i          (gap),
        .wfg_drive_spi_sclk_o (sclk),
        .wfg_drive_spi_cs_no  (cs_no),
        .wfg_drive_spi_sdo_o  (sdo),
        .busy_o               (busy),
        .dbg_state_o          (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input logic [31:0] d, input logic l, input logic use_sync);
        int w;
        @(negedge clk);
        tdata  = d;
        tlast  = l;
        tvalid = 1'b1;
        sync   = use_sync;
        w      = 0;
        #1;
        while (!tready && w < 300) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("handshake_wait", {31'b0, (w < 300)}, 32'd1);
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        sync   = 1'b0;
    endtask

    // Watch the pins until the block has been idle for 4 cycles.
    task automatic capture(input int sel, input int budget);
        logic prev_sclk, prev_sdo, prev_busy, prev_act, act, samp_lvl;
        int   idle_run;
        bit   seen_busy, done;
        cap_cs_cycles = 0; cap_edges = 0; cap_runs = 0; cap_other = 0;
        cap_busy_falls = 0; cap_gap = 0; cap_bad_launch = 0; cap_rx = '0;
        cap_timeout = 1;
        prev_sclk = sclk; prev_sdo = sdo; prev_busy = busy; prev_act = 1'b0;
        samp_lvl  = cpol ^ cpha ^ 1'b1;
        idle_run  = 0; seen_busy = 0; done = 0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk);
            act = (cs_no[sel] == sspol);
            if (act) cap_cs_cycles++;
            if (act && !prev_act) cap_runs++;
            for (int i = 0; i < 4; i++) begin
                if (i != sel && cs_no[i] == sspol) cap_other++;
            end
            if (sclk != prev_sclk && sclk == samp_lvl) begin
                if (sdo != prev_sdo) cap_bad_launch++;
                if (lsb) begin
                    if (cap_edges < 32) cap_rx[cap_edges] = sdo;
                end else begin
                    cap_rx = {cap_rx[30:0], sdo};
                end
                cap_edges++;
            end
            if (dbg_state == ST_GAP) cap_gap++;
            if (prev_busy && !busy) cap_busy_falls++;
            if (busy) begin
                seen_busy = 1;
                idle_run  = 0;
            end else if (seen_busy) begin
                idle_run++;
            end
            if (idle_run >= 4) begin
                done        = 1;
                cap_timeout = 0;
            end
            prev_sclk = sclk; prev_sdo = sdo; prev_busy = busy; prev_act = act;
        end
    endtask

    task automatic check_frame(input string tag, input int cs_cycles, input int edges,
                               input int gap_cycles);
        check({tag, "_timeout"}, cap_timeout, 0);
        check({tag, "_rx"}, cap_rx, exp_q.pop_front());
        check({tag, "_cs_cycles"}, cap_cs_cycles, cs_cycles);
        check({tag, "_edges"}, cap_edges, edges);
        check({tag, "_cs_runs"}, cap_runs, 1);
        check({tag, "_other_cs"}, cap_other, 0);
        check({tag, "_launch"}, cap_bad_launch, 0);
        check({tag, "_gap_cycles"}, cap_gap, gap_cycles);
        check({tag, "_busy_falls"}, cap_busy_falls, 1);
    endtask

    initial begin
        int w;
        rst_n = 1'b0; sync = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = '0;
        en = 1'b1; div = 8'd0; flen = 5'd7; cpol = 1'b0; cpha = 1'b0; lsb = 1'b0;
        cs_sel = 2'd0; sspol = 1'b0; burst = 1'b0; gap = 8'd0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_sclk", {31'b0, sclk}, 0);
        check("rst_sdo", {31'b0, sdo}, 0);
        check("rst_cs", {28'b0, cs_no}, 32'hF);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_tready", {31'b0, tready}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // mode 0, MSB first, 8 bits, H=1
        exp_q.push_back(32'hA5);
        send(32'hA5, 1'b1, 1'b1);
        capture(0, 400);
        check_frame("m0", 18, 8, 1);

        // mode 3, LSB first, 16 bits, H=3
        cpol = 1'b1; cpha = 1'b1; lsb = 1'b1; flen = 5'd15; div = 8'd2;
        repeat (2) @(negedge clk);
        check("m3_sclk_idle", {31'b0, sclk}, 1);
        exp_q.push_back(32'h1234);
        send(32'hFFFF_1234, 1'b1, 1'b1);
        capture(0, 600);
        check_frame("m3", 102, 16, 3);
        check("m3_sclk_after", {31'b0, sclk}, 1);

        // burst of three beats, gap=3
        cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; flen = 5'd7; div = 8'd0;
        burst = 1'b1; gap = 8'd3;
        repeat (2) @(negedge clk);
        exp_q.push_back(32'h0011_2233);
        fork
            begin
                send(32'h11, 1'b0, 1'b1);
                send(32'h22, 1'b0, 1'b0);
                send(32'h33, 1'b1, 1'b0);
            end
            capture(0, 800);
        join
        check_frame("burst", 54, 24, 4);

        // no start without sync, or with enable low
        burst = 1'b0; gap = 8'd0;
        @(negedge clk);
        tvalid = 1'b1; tdata = 32'hFF; sync = 1'b0;
        #1;
        check("nosync_tready", {31'b0, tready}, 0);
        repeat (6) @(negedge clk);
        check("nosync_busy", {31'b0, busy}, 0);
        check("nosync_cs", {28'b0, cs_no}, 32'hF);
        en = 1'b0; sync = 1'b1;
        #1;
        check("noen_tready", {31'b0, tready}, 0);
        repeat (6) @(negedge clk);
        check("noen_busy", {31'b0, busy}, 0);
        tvalid = 1'b0; sync = 1'b0; en = 1'b1;

        // cs_sel=2, active-high CS, burst held in HOLD then released by en=0
        cs_sel = 2'd2; sspol = 1'b1; burst = 1'b1;
        repeat (2) @(negedge clk);
        check("sel2_cs_idle", {28'b0, cs_no}, 32'h0);
        exp_q.push_back(32'h3C);
        fork
            begin
                send(32'h3C, 1'b0, 1'b1);
                capture(2, 600);
            end
            begin
                w = 0;
                while (dbg_state != ST_HOLD && w < 300) begin
                    @(negedge clk);
                    w++;
                end
                check("sel2_hold_reached", {29'b0, dbg_state}, {29'b0, ST_HOLD});
                check("sel2_hold_cs", {28'b0, cs_no}, 32'h4);
                repeat (5) @(negedge clk);
                check("sel2_hold_stay", {29'b0, dbg_state}, {29'b0, ST_HOLD});
                en = 1'b0;
            end
        join
        check_frame("sel2", 24, 8, 1);
        check("sel2_cs_released", {28'b0, cs_no}, 32'h0);
        en = 1'b1; cs_sel = 2'd0; sspol = 1'b0; burst = 1'b0;

        // asynchronous reset in the middle of SHIFT
        div = 8'd3;
        repeat (2) @(negedge clk);
        send(32'hFF, 1'b1, 1'b1);
        w = 0;
        while (!(dbg_state == ST_SHIFT && sclk && sdo) && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("rstmid_reached", {31'b0, (w < 200)}, 1);
        rst_n = 1'b0;
        #1;
        check("rstmid_sclk", {31'b0, sclk}, 0);
        check("rstmid_sdo", {31'b0, sdo}, 0);
        check("rstmid_cs", {28'b0, cs_no}, 32'hF);
        check("rstmid_busy", {31'b0, busy}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1; div = 8'd0;
        repeat (2) @(negedge clk);
        exp_q.push_back(32'hA5);
        send(32'hA5, 1'b1, 1'b1);
        capture(0, 400);
        check_frame("post_rst", 18, 8, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
